// File: rtl/trace_capture_pkg.sv
// Shared types for the trace recorder: FSM state encoding.
// Imported by the top and the entry buffer.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/trace_capture_fifo.sv
// Synchronous DEPTH x DW entry buffer with extra-bit pointers; head is shown combinationally.
// Writes when full and reads when empty are dropped.
module trace_capture_fifo #(
    parameter int DW    = 12,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [DW-1:0]            i_wr_dat,
    input  logic                     i_rd_en,
    output logic [DW-1:0]            o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;

    assign o_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (o_count == (AW+1)'(DEPTH));
    assign w_empty  = (o_count == '0);
    assign w_wr     = i_wr_en && !w_full;
    assign w_rd     = i_rd_en && !w_empty;
    assign o_rd_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_dat;
    end

endmodule

// File: rtl/trace_capture.sv
// Change-only probe recorder: stores {timestamp, probe} on each probe change, then drains oldest-first.
// Write lands the same edge as the change; read port pops on valid&&ready, data held while stalled.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int TS_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_arm,
    input  logic                      i_stop,
    input  logic [WIDTH-1:0]          i_probe,
    input  logic                      i_rd_ready,
    output logic                      o_rd_valid,
    output logic [TS_W+WIDTH-1:0]     o_rd_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_busy,
    output logic                      o_trunc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = TS_W + WIDTH;
    localparam logic [TS_W-1:0] TS_MAX = '1;
    localparam logic [CW-1:0]   LAST   = CW'(DEPTH - 1);

    state_t           r_state;
    logic [TS_W-1:0]  r_ts;
    logic [WIDTH-1:0] r_prev;
    logic             r_busy;
    logic             r_trunc;

    logic             w_change;
    logic             w_wr_en;
    logic [EW-1:0]    w_wr_dat;
    logic [EW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_rd_valid;
    logic             w_pop;

    assign w_change   = (i_probe != r_prev);
    assign w_wr_en    = ((r_state == ST_IDLE) && i_arm) ||
                        ((r_state == ST_CAPTURE) && w_change);
    // The arm sample is always stamped zero; capture samples use the running timestamp.
    assign w_wr_dat   = (r_state == ST_IDLE) ? {TS_W'(0), i_probe} : {r_ts, i_probe};
    assign w_rd_valid = (r_state == ST_DRAIN) && (w_count != '0);
    assign w_pop      = w_rd_valid && i_rd_ready;

    trace_capture_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_en  (w_wr_en),
        .i_wr_dat (w_wr_dat),
        .i_rd_en  (w_pop),
        .o_rd_dat (w_head),
        .o_count  (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ts    <= '0;
            r_prev  <= '0;
            r_busy  <= 1'b0;
            r_trunc <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_arm) begin
                        r_state <= ST_CAPTURE;
                        r_prev  <= i_probe;
                        r_ts    <= TS_W'(1);
                        r_trunc <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_prev <= i_probe;
                    if (r_ts != TS_MAX) r_ts <= r_ts + TS_W'(1);
                    // A filling write wins over stop and marks the capture as cut short.
                    if (w_change && (w_count == LAST)) begin
                        r_trunc <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else if (i_stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_count == '0) || (w_pop && (w_count == CW'(1)))) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_valid = w_rd_valid;
    assign o_rd_data  = w_rd_valid ? w_head : '0;
    assign o_count    = w_count;
    assign o_busy     = r_busy;
    assign o_trunc    = r_trunc;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture (WIDTH=2, DEPTH=4, TS_W=4): directed scenarios then random traffic.
module tb_trace_capture;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
    localparam int TS_W  = 4;
    localparam int TSMAX = 15;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       stop;
    logic [1:0] probe;
    logic       rd_ready;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic [2:0] count;
    logic       busy;
    logic       trunc;

    trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_arm      (arm),
        .i_stop     (stop),
        .i_probe    (probe),
        .i_rd_ready (rd_ready),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_count    (count),
        .o_busy     (busy),
        .o_trunc    (trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    // Reference model: a capture/drain flag pair, cycles since arm, and a queue of expected entries.
    bit         m_cap, m_drain, m_trunc;
    int         m_cnt, m_k;
    logic [1:0] m_prev;
    logic [5:0] exp_q[$];
    logic [5:0] act_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ts;
        if (rst) begin
            m_cap = 0; m_drain = 0; m_trunc = 0; m_cnt = 0; m_k = 0; m_prev = '0;
            exp_q.delete();
        end else if (!m_cap && !m_drain) begin
            if (arm) begin
                exp_q.push_back({4'd0, probe});
                m_cnt = 1; m_prev = probe; m_k = 1; m_trunc = 0; m_cap = 1;
            end
        end else if (m_cap) begin
            if (probe != m_prev) begin
                ts = (m_k > TSMAX) ? TSMAX : m_k;
                exp_q.push_back({ts[3:0], probe});
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_trunc = 1; m_cap = 0; m_drain = 1;
                end
            end
            if (m_cap && stop) begin
                m_cap = 0; m_drain = 1;
            end
            m_prev = probe;
            m_k++;
        end else begin
            if (m_cnt == 0) m_drain = 0;
            else if (rd_ready) begin
                m_cnt--;
                if (m_cnt == 0) m_drain = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        n_tests++;
        if (busy) begin
            n_fail++;
            $display("FAIL %s: still busy after %0d cycles", name, n);
        end
    endtask

    task automatic compare_log(input string name, input logic [5:0] ex[$]);
        check({name, "_n"}, act_log.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            check(name, (i < act_log.size()) ? act_log[i] : 6'h3F, ex[i]);
    endtask

    // Monitor: every cycle compare flags against the model and pop the scoreboard on a read.
    always @(negedge clk) begin
        if (mon_en) begin
            check("rd_valid", rd_valid, (m_drain && m_cnt > 0));
            check("count", count, m_cnt);
            check("busy", busy, (m_cap || m_drain));
            check("trunc", trunc, m_trunc);
            if (rd_valid) begin
                if (exp_q.size() == 0) check("rd_extra", rd_data, 6'h3F);
                else begin
                    check("rd_data", rd_data, exp_q[0]);
                    if (rd_ready) begin
                        act_log.push_back(rd_data);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    logic       p_busy, p_valid;
    logic [1:0] p_probe;
    always @(negedge clk) begin
        if (mon_en && (busy !== p_busy || rd_valid !== p_valid || probe !== p_probe))
            $display("[TB] t=%0t busy=%0b rd_valid=%0b probe=%b count=%0d rd_data=%h",
                     $time, busy, rd_valid, probe, count, rd_data);
        p_busy = busy; p_valid = rd_valid; p_probe = probe;
    end

    initial begin
        logic [5:0] ex[$];
        rst = 1; arm = 0; stop = 0; probe = 2'b00; rd_ready = 1;
        m_cap = 0; m_drain = 0; m_trunc = 0; m_cnt = 0; m_k = 0; m_prev = '0;

        // 1: reset
        tick();
        mon_en = 1;
        tick();
        rst = 0;
        check("rst_valid", rd_valid, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_trunc", trunc, 0);
        check("rst_data", rd_data, 0);

        // 2: basic capture and drain
        act_log.delete();
        arm = 1; probe = 2'b00; tick();
        arm = 0; tick(); tick();
        probe = 2'b01; tick(); tick();
        probe = 2'b11; tick(); tick();
        stop = 1; tick();
        stop = 0;
        wait_idle("t2_drain");
        ex = '{6'h00, 6'h0D, 6'h17};
        compare_log("t2_entry", ex);
        check("t2_trunc", trunc, 0);

        // 3: toggling fills the buffer
        rd_ready = 0;
        arm = 1; probe = 2'b00; tick();
        arm = 0;
        for (int i = 1; i <= 5; i++) begin
            probe = (i % 2 == 1) ? 2'b01 : 2'b00;
            tick();
        end
        check("t3_count", count, 4);
        check("t3_trunc", trunc, 1);
        check("t3_busy", busy, 1);

        // 4: stalled reader sees a steady head
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_valid", rd_valid, 1);
            check("t4_data", rd_data, 6'h00);
            check("t4_count", count, 4);
        end

        // 5: reset mid-drain, then a fresh capture
        rd_ready = 1; tick(); tick();
        rd_ready = 0;
        check("t5_count2", count, 2);
        rst = 1; tick();
        rst = 0;
        check("t5_count", count, 0);
        check("t5_valid", rd_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_trunc", trunc, 0);
        act_log.delete();
        arm = 1; probe = 2'b10; tick();
        arm = 0; probe = 2'b11; tick();
        stop = 1; tick();
        stop = 0; rd_ready = 1;
        wait_idle("t5_drain");
        ex = '{6'h02, 6'h07};
        compare_log("t5_entry", ex);

        // 6: timestamp saturation; stray stop in IDLE and arm in CAPTURE are ignored
        act_log.delete();
        stop = 1; tick();
        stop = 0;
        check("t6_idle_stop", busy, 0);
        arm = 1; probe = 2'b01; tick();
        arm = 0;
        for (int i = 1; i <= 20; i++) begin
            arm = (i == 10);
            tick();
        end
        arm = 0; probe = 2'b10; tick();
        stop = 1; tick();
        stop = 0;
        wait_idle("t6_drain");
        ex = '{6'h01, 6'h3E};
        compare_log("t6_entry", ex);
        check("t6_trunc", trunc, 0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(299) == 0);
            arm      = ($urandom_range(7) == 0);
            stop     = ($urandom_range(23) == 0);
            rd_ready = ($urandom_range(2) != 0);
            if ($urandom_range(1) == 0) probe = 2'($urandom_range(3));
            tick();
        end
        rst = 0; arm = 0; stop = 1; rd_ready = 1;
        tick();
        stop = 0;
        wait_idle("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
